// File: rtl/mem_pkg.sv
// Shared encodings for the byte-lane data memory and its load aligner.
package mem_pkg;

    // Number of byte lanes in one memory word.
    localparam int LANES     = 4;
    localparam int WORD_BITS = LANES * 8;

    // Access size as carried on req_size.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_t;

    // Controller state: SCRUB zeroes the array, IDLE serves requests.
    typedef enum logic {
        ST_SCRUB = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Byte enables for a store of the given size at the given byte lane.
    function automatic logic [LANES-1:0] lane_enables(input size_t size, input logic [1:0] lane);
        logic [LANES-1:0] be;
        be = '0;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// Shifts the selected byte/halfword of a read word down to bit 0 and
// applies sign or zero extension. Words pass through untouched.
module load_align
    import mem_pkg::*;
(
    input  logic [WORD_BITS-1:0] word,
    input  logic [1:0]           lane,
    input  size_t                size,
    input  logic                 sign_ext,
    output logic [WORD_BITS-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte/half and extend it to a full word.
    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        result   = word;
        case (size)
            SIZE_BYTE: result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: result = {{16{sign_ext & half_sel[15]}}, half_sel};
            default:   result = word;
        endcase
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-lane data memory for the MEM stage: synchronous-read array with
// byte-enable writes, a scrub state machine that zeroes the array after
// reset or on request, and a valid/ready request port with a one-cycle
// response strobe.
//
// Handshake: a request is taken on any rising edge where req_valid and
// req_ready are both high; exactly one cycle later rsp_valid pulses for one
// cycle carrying rsp_rdata/rsp_error. There is no response backpressure.
module data_memory_bytelane
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_BITS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  init_done,
    output state_t                debug_state
);

    localparam int WORDS = 1 << DEPTH_BITS;

    // Storage; contents are only ever cleared by the scrub.
    logic [DATA_WIDTH-1:0] mem [WORDS];

    state_t                state_q, state_d;
    logic [DEPTH_BITS-1:0] cnt_q, cnt_d;

    size_t                 size;
    logic [DEPTH_BITS-1:0] idx;
    logic [1:0]            lane;
    logic                  range_err;
    logic                  align_err;
    logic                  req_err;
    logic                  accept;
    logic                  do_store;

    logic [LANES-1:0]      wr_be;
    logic [DEPTH_BITS-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic                  rsp_load_q;
    logic [1:0]            lane_q;
    size_t                 size_q;
    logic                  signed_q;
    logic [DATA_WIDTH-1:0] aligned;

    assign size      = size_t'(req_size);
    assign idx       = req_addr[DEPTH_BITS+1:2];
    assign lane      = req_addr[1:0];
    assign range_err = |(req_addr >> (DEPTH_BITS + 2));
    assign req_err   = (size == SIZE_RSVD) | align_err | range_err;

    assign req_ready   = (state_q == ST_IDLE);
    assign init_done   = (state_q == ST_IDLE);
    assign debug_state = state_q;
    assign accept      = req_valid & req_ready;
    assign do_store    = accept & req_write & ~req_err;

    // Alignment check: halves need an even address, words a 4-byte one.
    always_comb begin
        align_err = 1'b0;
        case (size)
            SIZE_HALF: align_err = lane[0];
            SIZE_WORD: align_err = |lane;
            default:   align_err = 1'b0;
        endcase
    end

    // Scrub / idle state and scrub counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SCRUB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: scrub walks every word once; a lone clear restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SCRUB: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {DEPTH_BITS{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear && !req_valid) begin
                    state_d = ST_SCRUB;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_SCRUB;
                cnt_d   = '0;
            end
        endcase
    end

    // Single write port shared by the scrubber and accepted stores;
    // store data is replicated so each enabled lane sees its own bytes.
    always_comb begin
        wr_be   = '0;
        wr_addr = idx;
        wr_data = '0;
        if (state_q == ST_SCRUB) begin
            wr_be   = '1;
            wr_addr = cnt_q;
            wr_data = '0;
        end else begin
            wr_be   = do_store ? lane_enables(size, lane) : '0;
            wr_addr = idx;
            case (size)
                SIZE_BYTE: wr_data = {4{req_wdata[7:0]}};
                SIZE_HALF: wr_data = {2{req_wdata[15:0]}};
                default:   wr_data = req_wdata;
            endcase
        end
    end

    // Array: per-lane write enables and a registered (read-first) read.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (wr_be[l]) begin
                mem[wr_addr][l*8 +: 8] <= wr_data[l*8 +: 8];
            end
        end
        rd_word <= mem[idx];
    end

    // Response strobe plus the lane/size/sign context the aligner needs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            lane_q      <= '0;
            size_q      <= SIZE_BYTE;
            signed_q    <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept & req_err;
            rsp_load_q  <= accept & ~req_write & ~req_err;
            lane_q      <= lane;
            size_q      <= size;
            signed_q    <= req_signed;
        end
    end

    load_align u_load_align (
        .word     (rd_word),
        .lane     (lane_q),
        .size     (size_q),
        .sign_ext (signed_q),
        .result   (aligned)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_err_q;
    assign rsp_rdata = rsp_load_q ? aligned : '0;

endmodule

// File: doc/data_memory_bytelane.md
Name: data_memory_bytelane

Overview:
Parametrised successor data memory for the MIPS core's MEM stage. Supports byte, halfword and word accesses with sign or zero extension and byte-lane writes. Read is synchronous (1-cycle), so the array maps to block RAM. Replaces the single-cycle reset clear with a sequential scrub state machine, and adds a valid/ready request port, a response strobe and an alignment/range error flag.

Parameters:
DATA_WIDTH, 32, word width in bits; must be 32 (4 byte lanes).
DEPTH_BITS, 8, log2 of word count; array holds 2^DEPTH_BITS words.
ADDR_WIDTH, 32, byte-address width.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
clear  in  1  request a full re-scrub; sampled only in IDLE.
req_valid  in  1  access request.
req_ready  out  1  block can accept a request this cycle.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  DATA_WIDTH  store data, right-aligned (low bits).
rsp_valid  out  1  one-cycle response strobe.
rsp_rdata  out  DATA_WIDTH  load result; 0 for stores and errors.
rsp_error  out  1  qualifies rsp_valid: misaligned, out-of-range or reserved size.
init_done  out  1  high once the scrub completes.

Behaviour:
- Reset (reset=0, asynchronous): state=SCRUB, scrub counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, init_done=0.
- Array contents are not reset directly; they are cleared only by the scrub.
- States: SCRUB, IDLE.
- SCRUB:
  - Writes 0 to word[counter] each cycle and increments counter.
  - After the write to word 2^DEPTH_BITS-1, moves to IDLE. Duration is exactly 2^DEPTH_BITS cycles.
  - req_ready=0 throughout; req_valid is ignored.
- IDLE:
  - req_ready=1 and init_done=1.
  - clear=1 with req_valid=0 -> SCRUB, counter=0, init_done drops the next cycle.
  - clear=1 with req_valid=1 -> the request takes priority; clear is ignored (the requester must hold clear).
- Accept: a request is accepted when req_valid & req_ready at a rising edge (cycle N). The response appears with rsp_valid=1 during cycle N+1 for exactly one cycle. There is no response backpressure.
- Throughput: one request per cycle; back-to-back requests produce back-to-back responses.
- Word index = req_addr[DEPTH_BITS+1:2]; byte lane = req_addr[1:0], little-endian (lane 0 = bits 7:0).
- Error conditions, any of:
  - size 3;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - any of req_addr[ADDR_WIDTH-1:DEPTH_BITS+2] nonzero.
  - Effect: the array is not written, rsp_error=1, rsp_rdata=0.
- Store:
  - Byte enables: byte -> lane addr[1:0]; half -> lanes addr[1]*2 and addr[1]*2+1; word -> all four.
  - Write data is replicated to the enabled lanes (byte = wdata[7:0], half = wdata[15:0]).
  - Unenabled lanes are unchanged.
  - Response: rsp_rdata=0, rsp_error=0.
- Load:
  - The selected byte or halfword is shifted to the low bits and extended per req_signed. A word is returned unmodified.
  - The lane select and size are registered with the request so extension is applied on the response cycle.
- Read-after-write:
  - A load in cycle N+1 to a word stored in cycle N returns the new data; this falls out naturally from the write landing at edge N.
  - A load and store cannot be accepted in the same cycle (single port).
- Reset asserted mid-scrub or mid-access: any pending response is dropped (rsp_valid=0 immediately) and the scrub restarts from 0.

Decomposition:
- Shared package mem_pkg:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - state encodings ST_SCRUB/ST_IDLE;
  - lane-count constant.
- Sub-module load_align (combinational): inputs are the raw word, registered lane, size and signed flag; output is the extended result. It is instantiated once on the response path.
- The array plus byte-enable write stay in the top module so block-RAM inference with byte-write is preserved.

Test Plan:
- Reset release with DEPTH_BITS=8 -> req_ready=0 for 256 cycles; init_done=1 in cycle 257. A word load at 0x3FC then returns 0x00000000.
- Word store 0x12345678 @0x10, then byte store 0xAB @0x11, then word load @0x10 -> 0x1234AB78, with rsp_valid exactly one cycle after each accept.
- Word store 0x80FF7F01 @0x20, then loads:
  - signed byte @0x22 -> 0xFFFFFFFF;
  - unsigned byte @0x23 -> 0x00000080;
  - signed half @0x20 -> 0x00007F01;
  - signed half @0x22 -> 0xFFFF80FF.
- Errors -> rsp_error=1, rsp_rdata=0, memory unchanged (verified by a follow-up word load):
  - half store @0x21;
  - word load @0x22;
  - any access @0x400;
  - req_size=3.
- Back-to-back: store 0xDEADBEEF @0x40 in cycle N, word load @0x40 in N+1 -> rsp_rdata=0xDEADBEEF in N+2.
- Mid-operation clear and reset:
  - clear=1 in IDLE with no request -> req_ready low for 2^DEPTH_BITS cycles, then prior data reads 0.
  - Drop reset to 0 while rsp_valid=1 -> rsp_valid clears asynchronously and the scrub restarts.
